blink_period_meter: RTL and testbench
=====================================

# blink_period_meter

Receive-side companion to the slow blink/clock divider. It samples an asynchronous slow square wave (`BLINK_IN`) in the `CLOCK_60Hz` domain and synchronizes it. It emits one-cycle edge pulses and measures the half-period in clock cycles. It also reports lock once the measured half-period is stable. Display and game-timing logic use it to align to, or check, a blink source.

## Interface
- `CNT_W`, 16: width of the interval counter and `HALF_PERIOD`.
- `TOL`, 1: allowed |measured − reference| in cycles for a match.
- `LOCK_COUNT`, 3: consecutive matches required to assert `LOCKED`.
- `TIMEOUT`, 255: cycles without an edge before declaring loss. Must be < 2^CNT_W − 1.

- `CLOCK_60Hz` in 1: sole clock, rising edge.
- `RESETn` in 1: asynchronous, active-low reset.
- `BLINK_IN` in 1: asynchronous slow square wave.
- `LEVEL` out 1: synchronized level of `BLINK_IN`.
- `TICK` out 1: one-cycle pulse on any detected edge.
- `RISE` out 1: one-cycle pulse on a detected rising edge.
- `HALF_PERIOD` out CNT_W: last measured cycles between consecutive edges.
- `LOCKED` out 1: half-period stable.
- `LOST` out 1: one-cycle pulse on timeout.

## Operation
- **Synchronizer and edge detect**
  - Two-flop synchronizer (`s1`, `s2`) feeds `prev` (which drives `LEVEL`).
  - Edge = `s2 != prev`; rising edge = `s2 & ~prev`.
  - Reset clears `s1`, `s2` and `prev` to 0. If `BLINK_IN` is high out of reset, a rising edge is detected. This is intended behaviour.
- **Interval counter `cnt`**
  - On an edge, `cnt <= 1`.
  - Otherwise `cnt <= cnt + 1`, saturating at 2^CNT_W − 1.
  - The measured interval is the value of `cnt` in the edge cycle.
- **State machine (IDLE, MEASURE, TRACK, LOCK)**
  - IDLE, on edge: go to MEASURE. No measurement is taken and `HALF_PERIOD` is unchanged.
  - MEASURE, on edge: `HALF_PERIOD <= cnt`, `REF <= cnt`, `match <= 0`, go to TRACK.
  - TRACK, on edge: `HALF_PERIOD <= cnt`.
    - If |cnt − REF| ≤ TOL: `match <= match + 1`. When `match + 1 == LOCK_COUNT`, go to LOCK and assert `LOCKED`.
    - Otherwise: `REF <= cnt`, `match <= 0`.
  - LOCK, on edge: `HALF_PERIOD <= cnt`.
    - A match holds the state. `REF` is not updated, so it does not drift.
    - A mismatch sets `LOCKED <= 0`, `REF <= cnt`, `match <= 0`, and goes to TRACK.
  - Timeout, in any state except IDLE, with no edge and `cnt == TIMEOUT`:
    - go to IDLE
    - `LOCKED <= 0`, `HALF_PERIOD <= 0`
    - `LOST` pulses for one cycle.
  - An edge and a timeout in the same cycle: the edge wins.
- The absolute difference is computed at CNT_W+1 bits. There is no wrap-around.

## Timing
- All outputs are registered. Reset values: `LEVEL=0`, `TICK=0`, `RISE=0`, `HALF_PERIOD=0`, `LOCKED=0`, `LOST=0`. Internal state is IDLE with `cnt=0`, `REF=0`, `match=0`.
- Asserting `RESETn` clears all outputs immediately, without waiting for a clock edge. This includes mid-measurement and while locked.
- Latency: `BLINK_IN` is first sampled at edge e0. `s2` updates at e1. The following are all registered at e2:
  - `TICK` / `RISE` go high
  - `LEVEL` changes
  - `HALF_PERIOD` / `LOCKED` update.
- Pulse outputs are high for exactly one cycle.
- Pulses narrower than one clock may be missed. This is not required to be detected.
- A source toggling every N cycles measures `HALF_PERIOD = N`. For example, a divider that toggles after its count reaches 30 measures 31.
- `LOCKED` asserts on the (LOCK_COUNT + 2)-th edge after IDLE, given steady input.

## Test plan
1. **Async reset.**
   - Stimulus: assert `RESETn` low between clock edges while `LOCKED=1`.
   - Response: all outputs are 0 before the next clock edge. After release with `BLINK_IN=0`, there is no `TICK`.
2. **Steady source.**
   - Stimulus: `BLINK_IN` toggles every 31 cycles from 0.
   - Response: the first edge gives `TICK=RISE=1` three edges after the change, with `HALF_PERIOD=0`. `HALF_PERIOD=31` from the second edge. `LOCKED=1` on the 5th edge. `RISE` pulses on every other `TICK`.
3. **Jitter.**
   - Stimulus: once locked, half-periods of 32, 30, 31.
   - Response: `LOCKED` stays 1 and `HALF_PERIOD` tracks 32, 30, 31.
   - Stimulus: next half-period of 33.
   - Response: `LOCKED` falls on that `TICK` and `HALF_PERIOD=33`. The 3rd subsequent 33 re-locks.
4. **Loss.**
   - Stimulus: stop toggling while locked.
   - Response: at `cnt=255`, `LOST` pulses once, with `LOCKED=0` and `HALF_PERIOD=0`. The next edge gives `TICK` with `HALF_PERIOD` still 0.
5. **Glitch.**
   - Stimulus: a 2-cycle high pulse during lock with a 31-cycle source.
   - Response: two `TICK`s with `HALF_PERIOD` 2 and 29 (or per edge timing), `LOCKED=0`, then re-lock after 3 matching 31s.
6. **Edge and timeout collision.**
   - Stimulus: an edge lands in the cycle where `cnt==TIMEOUT`.
   - Response: no `LOST`, and `HALF_PERIOD=255`.

Source files
------------

// File: rtl/blink_period_meter.sv
// Blink period meter: synchronizes a slow square wave, pulses on its edges,
// measures the half-period in clock cycles and flags lock / loss of signal.
module blink_period_meter #(
  parameter int CNT_W      = 16,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic             CLOCK_60Hz,
  input  logic             RESETn,
  input  logic             BLINK_IN,
  output logic             LEVEL,
  output logic             TICK,
  output logic             RISE,
  output logic [CNT_W-1:0] HALF_PERIOD,
  output logic             LOCKED,
  output logic             LOST
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_TRACK,
    S_LOCK
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [MW-1:0]    match_q, match_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;
  logic             tick_q, rise_q;

  logic             tog_w, rise_w, near_w, tout_w;
  logic [CNT_W:0]   diff_w, absd_w;
  logic [MW-1:0]    match_inc;

  assign tog_w  = s2_q ^ prev_q;
  assign rise_w = s2_q & ~prev_q;

  // One extra bit keeps the difference from wrapping.
  assign diff_w = {1'b0, cnt_q} - {1'b0, ref_q};
  assign absd_w = diff_w[CNT_W] ? (~diff_w + (CNT_W+1)'(1))
                                : diff_w;
  assign near_w = absd_w <= (CNT_W+1)'(TOL);

  assign match_inc = match_q + MW'(1);

  assign tout_w = !tog_w && (state_q != S_IDLE) &&
                  (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (tog_w) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    ref_d    = ref_q;
    match_d  = match_q;
    locked_d = locked_q;
    lost_d   = 1'b0;
    if (tog_w) begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_MEASURE;
        end
        S_MEASURE: begin
          hp_d    = cnt_q;
          ref_d   = cnt_q;
          match_d = '0;
          state_d = S_TRACK;
        end
        S_TRACK: begin
          hp_d = cnt_q;
          if (near_w) begin
            match_d = match_inc;
            if (match_inc == MW'(LOCK_COUNT)) begin
              state_d  = S_LOCK;
              locked_d = 1'b1;
            end
          end else begin
            ref_d   = cnt_q;
            match_d = '0;
          end
        end
        S_LOCK: begin
          // Reference stays frozen while locked so it cannot drift.
          hp_d = cnt_q;
          if (!near_w) begin
            locked_d = 1'b0;
            ref_d    = cnt_q;
            match_d  = '0;
            state_d  = S_TRACK;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (tout_w) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
      hp_d     = '0;
      lost_d   = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_60Hz or negedge RESETn) begin
    if (!RESETn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      ref_q    <= '0;
      hp_q     <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      tick_q   <= 1'b0;
      rise_q   <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      s1_q     <= BLINK_IN;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      hp_q     <= hp_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      tick_q   <= tog_w;
      rise_q   <= rise_w;
      state_q  <= state_d;
    end
  end

  assign LEVEL       = prev_q;
  assign TICK        = tick_q;
  assign RISE        = rise_q;
  assign HALF_PERIOD = hp_q;
  assign LOCKED      = locked_q;
  assign LOST        = lost_q;

endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter: random toggle intervals checked cycle by
// cycle against a timestamp-based reference model.
module tb_blink_period_meter;

  localparam int TOUT = 255;
  localparam int TOLR = 1;
  localparam int LCNT = 3;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        blink = 1'b0;
  logic        level, tick, rise, locked, lost;
  logic [15:0] hp;

  always #5 clk = ~clk;

  blink_period_meter dut (
    .CLOCK_60Hz (clk),
    .RESETn     (rst_n),
    .BLINK_IN   (blink),
    .LEVEL      (level),
    .TICK       (tick),
    .RISE       (rise),
    .HALF_PERIOD(hp),
    .LOCKED     (locked),
    .LOST       (lost)
  );

  int n_chk = 0;
  int n_fail = 0;
  int lost_cnt = 0;
  int tick_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  // Reference model: edge k is the k-th clock after reset release.
  int       k, last, mst, mref, mmatch, mhp;
  bit       has_last, mlocked, mtick, mrise, mlost, mlevel;
  bit [3:0] hist;

  task automatic m_reset();
    k = 0; last = 0; has_last = 0;
    mst = 0; mref = 0; mmatch = 0; mhp = 0;
    mlocked = 0; mtick = 0; mrise = 0; mlost = 0; mlevel = 0;
    hist = '0;
  endtask

  task automatic m_step(input bit in);
    int iv, d;
    bit e;
    k++;
    hist = {hist[2:0], in};
    e      = hist[2] != hist[3];
    mtick  = e;
    mrise  = hist[2] && !hist[3];
    mlevel = hist[2];
    iv = has_last ? k - last : k - 1;
    if (iv > CMAX) iv = CMAX;
    d = iv - mref;
    if (d < 0) d = -d;
    mlost = 0;
    if (e) begin
      case (mst)
        0: mst = 1;
        1: begin mhp = iv; mref = iv; mmatch = 0; mst = 2; end
        2: begin
          mhp = iv;
          if (d <= TOLR) begin
            mmatch++;
            if (mmatch == LCNT) begin mst = 3; mlocked = 1; end
          end else begin
            mref = iv; mmatch = 0;
          end
        end
        default: begin
          mhp = iv;
          if (d > TOLR) begin
            mlocked = 0; mref = iv; mmatch = 0; mst = 2;
          end
        end
      endcase
      last = k;
      has_last = 1;
    end else if (mst != 0 && iv == TOUT) begin
      mst = 0; mlocked = 0; mhp = 0; mlost = 1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      m_step(blink);
      #1;
      check("level", int'(level), int'(mlevel));
      check("tick", int'(tick), int'(mtick));
      check("rise", int'(rise), int'(mrise));
      check("half_period", int'(hp), mhp);
      check("locked", int'(locked), int'(mlocked));
      check("lost", int'(lost), int'(mlost));
      if (lost) lost_cnt++;
      if (tick) tick_cnt++;
    end
  endtask

  task automatic toggle(input int n);
    blink = ~blink;
    step(n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_rise"}, int'(rise), 0);
    check({tag, "_hp"}, int'(hp), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_lost"}, int'(lost), 0);
  endtask

  initial begin
    int n;
    m_reset();
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    step(5 + $urandom_range(0, 10));

    // Steady 31-cycle source
    repeat (8) toggle(31);
    check("steady_locked", int'(locked), 1);
    check("steady_hp", int'(hp), 31);

    // Jitter within tolerance, then a step to 33 and relock
    toggle(32); toggle(30); toggle(31);
    check("jitter_locked", int'(locked), 1);
    repeat (5) toggle(33);
    check("relock33_locked", int'(locked), 1);
    check("relock33_hp", int'(hp), 33);

    // Loss of signal
    lost_cnt = 0;
    step(300);
    check("loss_pulses", lost_cnt, 1);
    check("loss_locked", int'(locked), 0);
    check("loss_hp", int'(hp), 0);
    tick_cnt = 0;
    toggle(5);
    check("after_loss_ticks", tick_cnt, 1);
    check("after_loss_hp", int'(hp), 0);

    // Glitch during lock
    repeat (8) toggle(31);
    check("preglitch_locked", int'(locked), 1);
    if (!blink) toggle(31);
    toggle(14); toggle(2); toggle(15);
    check("glitch_unlock", int'(locked), 0);
    repeat (6) toggle(31);
    check("glitch_relock", int'(locked), 1);

    // Asynchronous reset while locked
    step(3);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    blink = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    tick_cnt = 0;
    step(20);
    check("post_reset_ticks", tick_cnt, 0);

    // Edge coinciding with the timeout count
    lost_cnt = 0;
    repeat (4) toggle(255);
    check("collide_hp", int'(hp), 255);
    check("collide_lost", lost_cnt, 0);

    // Random intervals
    repeat (150) begin
      if ($urandom_range(0, 9) == 0) n = $urandom_range(250, 258);
      else if ($urandom_range(0, 1) == 1) n = $urandom_range(29, 33);
      else n = $urandom_range(1, 40);
      toggle(n);
    end
    step(300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
